// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: FSM state encoding,
// lane-0 size masks carried on CORE_BE[3:0], and the default timeout.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/dmem_access_unit_if.sv
// Bus bundles for the data-memory access unit.
// dmem_core_if: load/store stage side (master = core, slave = access unit).
// dmem_mem_if:  SRAM side (master = access unit, slave = SRAM).
interface dmem_core_if;
  logic        CORE_CSN;
  logic        CORE_WEN;
  logic [4:0]  CORE_BE;
  logic [31:0] CORE_ADDR;
  logic [31:0] CORE_WDATA;
  logic [31:0] CORE_RDATA;
  logic        CORE_STALL;
  logic        CORE_ERR;

  modport master (
    output CORE_CSN, CORE_WEN, CORE_BE, CORE_ADDR, CORE_WDATA,
    input  CORE_RDATA, CORE_STALL, CORE_ERR
  );

  modport slave (
    input  CORE_CSN, CORE_WEN, CORE_BE, CORE_ADDR, CORE_WDATA,
    output CORE_RDATA, CORE_STALL, CORE_ERR
  );
endinterface

interface dmem_mem_if #(parameter int AWIDTH = 12);
  logic              MEM_CSN;
  logic              MEM_WEN;
  logic [3:0]        MEM_BE;
  logic [AWIDTH-1:0] MEM_ADDR;
  logic [31:0]       MEM_DI;
  logic [31:0]       MEM_DOUT;
  logic              MEM_READY;

  modport master (
    output MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI,
    input  MEM_DOUT, MEM_READY
  );

  modport slave (
    input  MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI,
    output MEM_DOUT, MEM_READY
  );
endinterface

// File: rtl/dmem_access_unit_load_ext.sv
// Load data extraction: picks the addressed lane out of a 32-bit SRAM word
// and sign- or zero-extends bytes and halfwords. Purely combinational so it
// can also sit on a cache fill path.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [3:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = data_i >> {offset_i, 3'b000};

  // Extend the lane-0 value according to access size; words pass through.
  always_comb begin
    data_o = shifted;
    if (size_i == BE_BYTE) begin
      data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
    end else if (size_i == BE_HALF) begin
      data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit between the core load/store stage and the SRAM.
// Aligns store data/byte enables, holds the SRAM request until MEM_READY,
// returns extended load data and stalls the core while busy.
// Optional feature macro: DMEM_TIMEOUT_EN (ACCESS timeout after TIMEOUT cycles).
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int AWIDTH  = 12,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RSTn,
  dmem_core_if.slave  core,
  dmem_mem_if.master  mem
);

  dmem_state_t state_q, state_d;

  logic              memCsn_q, memCsn_d;
  logic              memWen_q, memWen_d;
  logic [3:0]        memBe_q, memBe_d;
  logic [AWIDTH-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memDi_q, memDi_d;
  logic [1:0]        offset_q, offset_d;
  logic [3:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       coreRdata_q, coreRdata_d;
  logic              coreErr_q, coreErr_d;

  logic              misaligned;
  logic [3:0]        beShift;
  logic [31:0]       wdataShift;
  logic [31:0]       loadData;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign misaligned = ((core.CORE_BE[3:0] == BE_HALF) && core.CORE_ADDR[0]) ||
                      ((core.CORE_BE[3:0] == BE_WORD) && (core.CORE_ADDR[1:0] != 2'b00));
  assign beShift    = core.CORE_BE[3:0] << core.CORE_ADDR[1:0];
  assign wdataShift = core.CORE_WDATA << {core.CORE_ADDR[1:0], 3'b000};

  dmem_load_ext u_load_ext (
    .data_i     (mem.MEM_DOUT),
    .offset_i   (offset_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (loadData)
  );

  // Next-state and next-register logic for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_d     = state_q;
    memCsn_d    = memCsn_q;
    memWen_d    = memWen_q;
    memBe_d     = memBe_q;
    memAddr_d   = memAddr_q;
    memDi_d     = memDi_q;
    offset_d    = offset_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    coreRdata_d = coreRdata_q;
    coreErr_d   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!core.CORE_CSN) begin
          if (misaligned) begin
            // Misaligned: no SRAM access, flag the error and finish at once.
            coreErr_d   = 1'b1;
            coreRdata_d = '0;
            state_d     = DONE;
          end else begin
            memCsn_d   = 1'b0;
            memWen_d   = core.CORE_WEN;
            memBe_d    = beShift;
            memAddr_d  = core.CORE_ADDR[AWIDTH+1:2];
            memDi_d    = wdataShift;
            offset_d   = core.CORE_ADDR[1:0];
            size_d     = core.CORE_BE[3:0];
            unsigned_d = core.CORE_BE[4];
`ifdef DMEM_TIMEOUT_EN
            cnt_d      = '0;
`endif
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem.MEM_READY) begin
          memCsn_d = 1'b1;
          if (memWen_q) begin
            coreRdata_d = loadData;
          end
          state_d = DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          memCsn_d    = 1'b1;
          coreErr_d   = 1'b1;
          coreRdata_d = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered SRAM/core outputs, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      memCsn_q    <= 1'b1;
      memWen_q    <= 1'b1;
      memBe_q     <= '0;
      memAddr_q   <= '0;
      memDi_q     <= '0;
      offset_q    <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      coreRdata_q <= '0;
      coreErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      memCsn_q    <= memCsn_d;
      memWen_q    <= memWen_d;
      memBe_q     <= memBe_d;
      memAddr_q   <= memAddr_d;
      memDi_q     <= memDi_d;
      offset_q    <= offset_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      coreRdata_q <= coreRdata_d;
      coreErr_q   <= coreErr_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  // Cycles spent in ACCESS without READY.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign core.CORE_STALL = ((state_q == IDLE) && !core.CORE_CSN) || (state_q == ACCESS);
  assign core.CORE_RDATA = coreRdata_q;
  assign core.CORE_ERR   = coreErr_q;
  assign mem.MEM_CSN     = memCsn_q;
  assign mem.MEM_WEN     = memWen_q;
  assign mem.MEM_BE      = memBe_q;
  assign mem.MEM_ADDR    = memAddr_q;
  assign mem.MEM_DI      = memDi_q;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Core-side data-memory access controller between the RISC-V core's load/store stage and the latency-modelled data SRAM. It accepts one load or store per request from the core and aligns store data and byte enables to the addressed lanes. It holds the SRAM request until the memory signals READY, then returns sign- or zero-extended load data. While the access is outstanding it stalls the core pipeline.

## Interface
Parameters:
- AWIDTH, 12: word-address width driven to the SRAM (byte address bits [AWIDTH+1:2]).
- TIMEOUT, 64: cycles in ACCESS before a timeout error (DMEM_TIMEOUT_EN only).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- CORE_CSN  in  1  request, active-low; held by the core while CORE_STALL=1.
- CORE_WEN  in  1  0 = store, 1 = load.
- CORE_BE  in  5  [3:0] lane-0 size mask (0001 byte, 0011 half, 1111 word); [4] = 1 zero-extend, 0 sign-extend (loads only).
- CORE_ADDR  in  32  byte address.
- CORE_WDATA  in  32  unshifted store data (rs2).
- CORE_RDATA  out  32  extended load data, valid in DONE.
- CORE_STALL  out  1  pipeline hold.
- CORE_ERR  out  1  one-cycle pulse on misaligned access or timeout.
- MEM_CSN  out  1  SRAM chip select, active-low.
- MEM_WEN  out  1  SRAM write enable, active-low.
- MEM_BE  out  4  shifted lane enables.
- MEM_ADDR  out  AWIDTH  word address.
- MEM_DI  out  32  shifted store data.
- MEM_DOUT  in  32  SRAM read data, valid when MEM_READY=1.
- MEM_READY  in  1  access complete.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, CORE_CSN=0, aligned: latch WEN, shifted BE (CORE_BE[3:0] << ADDR[1:0]), sign flag, ADDR[1:0], ADDR[AWIDTH+1:2], and WDATA << 8*ADDR[1:0]. Go to ACCESS.
- Misaligned request: half with ADDR[0]=1, or word with ADDR[1:0]≠0. Pulse CORE_ERR, issue no memory access, go to DONE with CORE_RDATA=0.
- ACCESS: MEM_CSN=0, with registered MEM_WEN/BE/ADDR/DI held stable. On MEM_READY=1, loads capture the extracted and extended MEM_DOUT into CORE_RDATA; then go to DONE.
- Load extraction: select lane by ADDR[1:0], then extend bit 7 (byte) or 15 (half), or zero-fill when BE[4]=1. Word passes through.
- DONE: CORE_STALL=0. The core advances at this edge. The request still visible in this cycle is ignored. Always go to IDLE next cycle.
- CORE_RDATA holds its value until the next load completes. Stores leave CORE_RDATA unchanged.

## Timing
- CORE_STALL = (IDLE & ~CORE_CSN) | ACCESS. It is combinational, so it is high in the request cycle.
- MEM_CSN is registered and first goes low the cycle after the request.
- Minimum access is 3 cycles: request (IDLE), ACCESS with READY=1, DONE. Each additional cycle without READY adds one ACCESS cycle.
- Back-to-back requests: the next request is accepted no earlier than the cycle after DONE.
- MEM_READY outside ACCESS is ignored.
- Reset (RSTn=0 at an edge, any state): state=IDLE, MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_DI=0, CORE_RDATA=0, CORE_ERR=0, timeout counter=0. An in-flight access is abandoned.

## Configuration
- DMEM_TIMEOUT_EN defined: a counter clears on ACCESS entry and increments each ACCESS cycle without READY. On reaching TIMEOUT, CORE_ERR pulses, MEM_CSN is released, and the FSM goes to DONE with CORE_RDATA=0.
- DMEM_TIMEOUT_EN undefined: no counter. ACCESS waits for READY indefinitely.

## Structure
- Shared package dmem_pkg: state encoding (IDLE/ACCESS/DONE), BE size constants (BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111), default TIMEOUT.
- Sub-module dmem_load_ext: combinational lane select plus sign/zero extension (inputs data, offset, size, unsigned flag). It is reused by any future cache fill path.

## Test plan
- Word load, addr 0x100, SRAM word 0x8899AABB, READY on first ACCESS cycle -> CORE_RDATA=0x8899AABB, STALL high exactly 2 cycles.
- Signed byte load, addr 0x103, same word -> RDATA=0xFFFFFF88. Unsigned (BE[4]=1) -> 0x00000088.
- Half store, addr 0x202, WDATA=0x0000CAFE -> MEM_BE=1100, MEM_DI=0xCAFE0000, MEM_ADDR=0x80, MEM_WEN=0.
- Latency 4 (READY on 4th ACCESS cycle) -> STALL high 5 cycles, MEM_CSN low 4 cycles, request signals stable throughout.
- Word load at 0x102 -> CORE_ERR pulse, MEM_CSN never low, RDATA=0. With DMEM_TIMEOUT_EN and TIMEOUT=8, READY tied 0 -> ERR after 8 ACCESS cycles.
- RSTn low during ACCESS -> next cycle IDLE, MEM_CSN=1, STALL=0, all outputs at reset values.
